// File: rtl/run_checker.sv
// Run controller for the single-cycle core: holds it in reset, runs it for a bounded
// number of cycles or until a halt PC, then checks registers against an expectation table.
module run_checker #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_CHECKS = 4,
    parameter int CHK_IDX_W  = 2,
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 20,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exp_we,
    input  logic [CHK_IDX_W-1:0]  exp_idx,
    input  logic [REG_ADDR_W-1:0] exp_reg,
    input  logic [XLEN-1:0]       exp_val,
    input  logic                  halt_en,
    input  logic [XLEN-1:0]       halt_pc,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       dbg_data,
    output logic                  core_rst,
    output logic                  core_run,
    output logic [REG_ADDR_W-1:0] dbg_addr,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [CHK_IDX_W:0]    fail_cnt,
    output logic [CHK_IDX_W-1:0]  first_fail_idx,
    output logic [CNT_W-1:0]      cycle_cnt
);

    typedef enum logic [1:0] {HOLD, RUN, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0]     HOLD_LIM = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]     RUN_LIM  = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [CHK_IDX_W-1:0] LAST_IDX = CHK_IDX_W'(NUM_CHECKS - 1);
    localparam logic [CHK_IDX_W-1:0] IDX_ONE  = CHK_IDX_W'(1);
    localparam logic [CHK_IDX_W:0]   FAIL_ONE = (CHK_IDX_W + 1)'(1);

    state_t state, state_nxt;

    logic [REG_ADDR_W-1:0] tbl_reg [NUM_CHECKS];
    logic [XLEN-1:0]       tbl_val [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] tbl_vld;

    logic [CNT_W-1:0]     hold_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [CHK_IDX_W-1:0] idx;
    logic [CHK_IDX_W-1:0] idx_nxt;
    logic                 halt_hit;
    logic                 budget_hit;
    logic                 last_idx;
    logic                 mismatch;
    logic                 tbl_wr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    assign cnt_inc    = sat_inc(cycle_cnt);
    assign halt_hit   = halt_en && (pc == halt_pc);
    assign budget_hit = (cnt_inc >= RUN_LIM);
    assign last_idx   = (idx == LAST_IDX);
    assign idx_nxt    = idx + IDX_ONE;
    assign mismatch   = tbl_vld[idx] && (dbg_data != tbl_val[idx]);
    assign tbl_wr     = exp_we && ((state == HOLD) || (state == RUN)) &&
                        (int'(exp_idx) < NUM_CHECKS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        core_rst  = 1'b0;
        core_run  = 1'b0;
        case (state)
            HOLD: begin
                core_rst = 1'b1;
                if (hold_cnt == HOLD_LIM) state_nxt = RUN;
            end
            RUN: begin
                core_run = 1'b1;
                if (halt_hit || budget_hit) state_nxt = CHECK;
            end
            CHECK: begin
                if (last_idx) state_nxt = DONE;
            end
            default: state_nxt = DONE;
        endcase
    end

    // Table contents carry no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (tbl_wr) begin
            tbl_reg[exp_idx] <= exp_reg;
            tbl_val[exp_idx] <= exp_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt       <= '0;
            cycle_cnt      <= '0;
            timed_out      <= 1'b0;
            idx            <= '0;
            dbg_addr       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            tbl_vld        <= '0;
        end else begin
            case (state)
                HOLD: hold_cnt <= sat_inc(hold_cnt);
                RUN: begin
                    cycle_cnt <= cnt_inc;
                    // Halt wins over budget when both land in the same cycle.
                    if (halt_hit || budget_hit) begin
                        timed_out <= !halt_hit;
                        idx       <= '0;
                        dbg_addr  <= tbl_reg[0];
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + FAIL_ONE;
                        if (fail_cnt == '0) first_fail_idx <= idx;
                    end
                    if (last_idx) begin
                        done <= 1'b1;
                        pass <= (fail_cnt == '0) && !mismatch;
                    end else begin
                        idx      <= idx_nxt;
                        dbg_addr <= tbl_reg[idx_nxt];
                    end
                end
                default: ;
            endcase
            if (tbl_wr) tbl_vld[exp_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_run_checker.sv
// Scoreboard bench for run_checker: a small behavioural core drives pc and the debug
// read port; expected end-of-run results come from a run-level reference model.
module tb_run_checker;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_CHECKS = 4;
    localparam int CHK_IDX_W  = 2;
    localparam int RST_CYCLES = 1;
    localparam int RUN_CYCLES = 20;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  exp_we = 1'b0;
    logic [CHK_IDX_W-1:0]  exp_idx = '0;
    logic [REG_ADDR_W-1:0] exp_reg = '0;
    logic [XLEN-1:0]       exp_val = '0;
    logic                  halt_en = 1'b0;
    logic [XLEN-1:0]       halt_pc = '0;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       dbg_data;
    logic                  core_rst;
    logic                  core_run;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic                  done;
    logic                  pass;
    logic                  timed_out;
    logic [CHK_IDX_W:0]    fail_cnt;
    logic [CHK_IDX_W-1:0]  first_fail_idx;
    logic [CNT_W-1:0]      cycle_cnt;

    run_checker #(
        .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_CHECKS(NUM_CHECKS),
        .CHK_IDX_W(CHK_IDX_W), .RST_CYCLES(RST_CYCLES), .RUN_CYCLES(RUN_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .exp_we(exp_we), .exp_idx(exp_idx), .exp_reg(exp_reg),
        .exp_val(exp_val), .halt_en(halt_en), .halt_pc(halt_pc), .pc(pc),
        .dbg_data(dbg_data), .core_rst(core_rst), .core_run(core_run),
        .dbg_addr(dbg_addr), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural core: register file, pc and a per-cycle write program.
    logic [XLEN-1:0] regs      [32];
    logic [XLEN-1:0] base_regs [32];
    logic            prog_en   [32];
    logic [4:0]      prog_reg  [32];
    logic [XLEN-1:0] prog_val  [32];
    int              ncyc;

    always @(posedge clk) begin
        if (core_rst) begin
            pc   <= '0;
            ncyc <= 0;
            for (int i = 0; i < 32; i++) regs[i] <= base_regs[i];
        end else if (core_run) begin
            pc   <= pc + 32'd4;
            ncyc <= ncyc + 1;
            if (ncyc < 32 && prog_en[ncyc] && prog_reg[ncyc] != 5'd0)
                regs[prog_reg[ncyc]] <= prog_val[ncyc];
        end
    end

    always_comb dbg_data = regs[dbg_addr];

    int rel_edges = 0;
    always @(posedge clk) begin
        if (rst) rel_edges <= 0;
        else     rel_edges <= rel_edges + 1;
    end

    // Test description
    logic            tbl_en  [NUM_CHECKS];
    logic            tbl_ovw [NUM_CHECKS];
    logic [4:0]      tbl_reg_a [NUM_CHECKS];
    logic [XLEN-1:0] tbl_val_a [NUM_CHECKS];
    logic            h_en;
    int              h_cyc;
    logic [XLEN-1:0] fin [32];

    typedef struct {
        logic            pass;
        logic            timed_out;
        int              fail_cnt;
        int              first_fail;
        int              cyc;
        int              lat;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Reference model: run length, final register state, check outcome.
    task automatic model(output exp_t e);
        int n;
        int fc;
        int ff;
        n = RUN_CYCLES;
        e.timed_out = 1'b1;
        if (h_en && h_cyc >= 1 && h_cyc <= RUN_CYCLES) begin
            n = h_cyc;
            e.timed_out = 1'b0;
        end
        for (int r = 0; r < 32; r++) fin[r] = base_regs[r];
        for (int j = 0; j < n; j++)
            if (prog_en[j] && prog_reg[j] != 5'd0) fin[prog_reg[j]] = prog_val[j];
        fc = 0;
        ff = 0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (tbl_en[i] && fin[tbl_reg_a[i]] != tbl_val_a[i]) begin
                if (fc == 0) ff = i;
                fc++;
            end
        end
        e.pass       = (fc == 0);
        e.fail_cnt   = fc;
        e.first_fail = ff;
        e.cyc        = n;
        e.lat        = RST_CYCLES + n + NUM_CHECKS;
        e.pc         = XLEN'(4 * n);
    endtask

    always @(negedge clk) begin
        if (done && !e_mon.pass === 1'bx) begin
        end
    end

    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (done && !done_q) begin
            if (sb_q.size() == 0) begin
                bound_fail("sb_underflow");
            end else begin
                e_mon = sb_q.pop_front();
                check("pass",           pass,           e_mon.pass);
                check("timed_out",      timed_out,      e_mon.timed_out);
                check("fail_cnt",       fail_cnt,       e_mon.fail_cnt);
                check("first_fail_idx", first_fail_idx, e_mon.first_fail);
                check("cycle_cnt",      cycle_cnt,      e_mon.cyc);
                check("done_latency",   rel_edges,      e_mon.lat);
                check("core_pc_frozen", pc,             e_mon.pc);
                check("core_run_low",   core_run,       0);
                check("core_rst_low",   core_rst,       0);
            end
        end
        done_q = done;
    end

    task automatic check_reset_vals();
        check("rst_core_rst",  core_rst,       1);
        check("rst_core_run",  core_run,       0);
        check("rst_dbg_addr",  dbg_addr,       0);
        check("rst_done",      done,           0);
        check("rst_pass",      pass,           0);
        check("rst_timed_out", timed_out,      0);
        check("rst_fail_cnt",  fail_cnt,       0);
        check("rst_first",     first_fail_idx, 0);
        check("rst_cycle_cnt", cycle_cnt,      0);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NUM_CHECKS; i++) begin
            tbl_en[i] = 1'b0; tbl_ovw[i] = 1'b0; tbl_reg_a[i] = '0; tbl_val_a[i] = '0;
        end
        for (int j = 0; j < 32; j++) begin
            prog_en[j] = 1'b0; prog_reg[j] = '0; prog_val[j] = '0;
            base_regs[j] = (j == 0) ? '0 : XLEN'(j * 1000 + 7);
        end
        h_en = 1'b0;
        h_cyc = 0;
    endtask

    task automatic prog_write(input int cyc, input int r, input int v);
        prog_en[cyc - 1]  = 1'b1;
        prog_reg[cyc - 1] = 5'(r);
        prog_val[cyc - 1] = XLEN'(v);
    endtask

    task automatic set_tbl(input int i, input int r, input int v);
        tbl_en[i] = 1'b1; tbl_reg_a[i] = 5'(r); tbl_val_a[i] = XLEN'(v);
    endtask

    // Pushes the model's expectation (optional), pulses rst, then loads the table.
    task automatic start_run(input bit push);
        exp_t e;
        model(e);
        if (push) sb_q.push_back(e);
        halt_en = h_en;
        halt_pc = XLEN'(4 * (h_cyc - 1));
        @(negedge clk);
        rst = 1'b1;
        exp_we = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (tbl_en[i]) begin
                if (tbl_ovw[i]) begin
                    exp_we = 1'b1; exp_idx = CHK_IDX_W'(i);
                    exp_reg = 5'($urandom_range(0, 7)); exp_val = ~tbl_val_a[i];
                    @(negedge clk);
                end
                exp_we = 1'b1; exp_idx = CHK_IDX_W'(i);
                exp_reg = tbl_reg_a[i]; exp_val = tbl_val_a[i];
                @(negedge clk);
            end
        end
        exp_we = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 200; k++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) bound_fail(name);
        repeat (3) @(negedge clk);
        check("done_sticky", done, 1);
    endtask

    task automatic wait_core_stop(input string name);
        for (int k = 0; k < 100; k++) begin
            if (!core_run && !core_rst) break;
            @(negedge clk);
        end
        if (core_run || core_rst) bound_fail(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stim();
        repeat (2) @(negedge clk);

        // x1 written to 2 on cycle 3; timeout run, entry matches
        clear_stim(); prog_write(3, 1, 2); set_tbl(0, 1, 2);
        start_run(1); wait_done("t1_done");

        // same run, entry expects 3
        clear_stim(); prog_write(3, 1, 2); set_tbl(0, 1, 3);
        start_run(1); wait_done("t2_done");

        // entries 1 and 3 mismatch
        clear_stim();
        prog_write(2, 1, 10); prog_write(4, 2, 20); prog_write(6, 3, 30); prog_write(8, 4, 40);
        set_tbl(0, 1, 10); set_tbl(1, 2, 21); set_tbl(2, 3, 30); set_tbl(3, 4, 41);
        start_run(1); wait_done("t3_done");

        // halt on run cycle 7; x2 write on cycle 9 must not happen; x0 compared too
        clear_stim(); h_en = 1'b1; h_cyc = 7;
        prog_write(3, 1, 55); prog_write(9, 2, 66);
        set_tbl(0, 1, 55); set_tbl(1, 2, 2007); set_tbl(2, 0, 0);
        start_run(1); wait_done("t4_done");

        // halt coincides with budget, empty table
        clear_stim(); h_en = 1'b1; h_cyc = 20;
        start_run(1); wait_done("t5_done");

        // table write during CHECK is ignored
        clear_stim(); prog_write(3, 1, 2); set_tbl(0, 1, 2);
        start_run(1);
        wait_core_stop("t6_stop");
        exp_we = 1'b1; exp_idx = 2'd1; exp_reg = 5'd1; exp_val = 32'd999;
        @(negedge clk);
        exp_we = 1'b0;
        wait_done("t6_done");

        // rst during CHECK aborts; rerun without writes sees an empty table
        clear_stim(); prog_write(3, 1, 2); set_tbl(0, 1, 999);
        start_run(0);
        wait_core_stop("t7_stop");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        clear_stim();
        begin
            exp_t e;
            model(e);
            sb_q.push_back(e);
        end
        rst = 1'b0;
        wait_done("t7_rerun");

        // randomized runs
        for (int t = 0; t < 40; t++) begin
            exp_t tmp;
            clear_stim();
            for (int j = 1; j < 32; j++) base_regs[j] = XLEN'($urandom_range(0, 7));
            for (int j = 0; j < RUN_CYCLES; j++) begin
                prog_en[j]  = 1'($urandom_range(0, 1));
                prog_reg[j] = 5'($urandom_range(0, 7));
                prog_val[j] = XLEN'($urandom_range(0, 7));
            end
            h_en  = 1'($urandom_range(0, 1));
            h_cyc = $urandom_range(10, 24);
            model(tmp);
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl_en[i]    = 1'($urandom_range(0, 1));
                tbl_ovw[i]   = 1'($urandom_range(0, 1));
                tbl_reg_a[i] = 5'($urandom_range(0, 7));
                tbl_val_a[i] = ($urandom_range(0, 1) == 1) ? fin[tbl_reg_a[i]]
                                                           : XLEN'($urandom_range(0, 7));
            end
            start_run(1);
            wait_done("rand_done");
        end

        check("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
